// File: rtl/fifo_rd_pkg.sv
// Shared constants for the burst FIFO reader.
// FSM encoding, skid buffer depth and pointer helper.
package fifo_rd_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam int unsigned SKID_DEPTH = 3;

  typedef logic [1:0] skid_ptr_t;

  function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
    return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid3.sv
// Three-entry circular output buffer.
// Pointers wrap modulo 3; occupancy runs 0..3.
module fifo_rd_skid3
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  skid_ptr_t         wr_ptr;
  skid_ptr_t         rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_16o_burst_rd.sv
// Burst reader: drains fixed-length bursts from a FIFO read port
// into a valid/ready stream through a 3-entry skid buffer.
module fifo_16o_burst_rd
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LVL_W      = 13,
  parameter int BURST_LEN  = 256,
  parameter int SKID_DEPTH = 3
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              enable,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic [LVL_W-1:0]  fifo_rd_level,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [0:0]       state;
  logic             inflight;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] sent;
  logic [1:0]       occ;
  logic             pop;
  logic             last_hs;
  logic             room;
  logic             start;

  assign busy    = (state == ST_BURST);
  assign room    = ({1'b0, occ} + {2'b0, inflight}) < 3'(SKID_DEPTH);
  assign start   = enable && (fifo_rd_level >= LVL_W'(BURST_LEN));

  // Room check counts in-flight reads so m_ready never reaches rd_en.
  assign fifo_rd_en = busy && !fifo_empty && room
                   && (issued < CNT_W'(BURST_LEN));

  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && (sent == CNT_W'(BURST_LEN - 1));
  assign pop     = m_valid && m_ready;
  assign last_hs = pop && m_last;

  fifo_rd_skid3 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
      issued   <= '0;
      sent     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (start) state <= ST_BURST;
        end
        (state == ST_BURST): begin
          if (last_hs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (last_hs) begin
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + CNT_W'(1);
        if (pop)        sent   <= sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_16o_burst_rd.sv
// Directed bench for fifo_16o_burst_rd with BURST_LEN=4.
// Behavioural FIFO model with 1-cycle read latency feeds the DUT.
module tb_fifo_16o_burst_rd;

  localparam int DATA_W = 16;
  localparam int LVL_W  = 13;
  localparam int BL     = 4;

  logic              clk = 1'b0;
  logic              rd_rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              m_ready = 1'b0;
  logic              stall_empty = 1'b0;
  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic [LVL_W-1:0]  fifo_rd_level;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;

  logic [DATA_W-1:0] fmem [64];
  int                wp = 0;
  int                rp = 0;
  logic [16:0]       cap [$];
  int                rd_total = 0;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  fifo_16o_burst_rd #(
    .DATA_W     (DATA_W),
    .LVL_W      (LVL_W),
    .BURST_LEN  (BL),
    .SKID_DEPTH (3)
  ) dut (
    .rd_clk        (clk),
    .rd_rst_n      (rd_rst_n),
    .enable        (enable),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_rd_level (fifo_rd_level),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
  );

  assign fifo_empty    = (wp == rp) || stall_empty;
  assign fifo_rd_level = LVL_W'(wp - rp);

  // FIFO model: data appears one cycle after rd_en; reset drops contents.
  always @(posedge clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rp <= wp;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rp];
      rp <= rp + 1;
    end
  end

  always @(posedge clk) begin
    if (rd_rst_n && m_valid && m_ready) cap.push_back({m_last, m_data});
    if (rd_rst_n && fifo_rd_en) rd_total <= rd_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    fmem[wp] = d;
    wp++;
  endtask

  task automatic push_run(input logic [DATA_W-1:0] first, input int n);
    for (int k = 0; k < n; k++) push(DATA_W'(first + k));
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic wait_cap(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (cap.size() < n && i < budget) begin
      nc();
      i++;
    end
    chk(tag, 32'(cap.size()), 32'(n));
  endtask

  task automatic chk_seq(input string tag, input int base,
                         input logic [DATA_W-1:0] first, input int n);
    logic [16:0] e;
    for (int k = 0; k < n; k++) begin
      e = {((k % BL) == BL - 1), DATA_W'(first + k)};
      if (base + k < cap.size()) chk(tag, 32'(cap[base + k]), 32'(e));
      else chk(tag, 32'hdead, 32'(e));
    end
  endtask

  int base;
  int r0;
  int i;

  initial begin
    nc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_rden", 32'(fifo_rd_en), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    rd_rst_n = 1'b1;

    // basic burst timing
    nc();
    enable = 1'b1;
    m_ready = 1'b1;
    base = cap.size();
    push_run(16'h0001, 4);
    chk("s1_n_busy", 32'(busy), 0);
    nc();
    chk("s1_n1_busy", 32'(busy), 1);
    chk("s1_n1_rden", 32'(fifo_rd_en), 1);
    chk("s1_n1_valid", 32'(m_valid), 0);
    nc();
    chk("s1_n2_valid", 32'(m_valid), 0);
    for (int k = 0; k < 4; k++) begin
      nc();
      chk("s1_valid", 32'(m_valid), 1);
      chk("s1_data", 32'(m_data), 32'(k + 1));
      chk("s1_last", 32'(m_last), 32'(k == 3));
    end
    nc();
    chk("s1_end_busy", 32'(busy), 0);
    chk("s1_end_valid", 32'(m_valid), 0);
    chk_seq("s1_seq", base, 16'h0001, 4);

    // back-pressure: only three reads fit
    m_ready = 1'b0;
    r0 = rd_total;
    base = cap.size();
    push_run(16'h0001, 4);
    repeat (10) nc();
    chk("s2_rd_pulses", 32'(rd_total - r0), 3);
    chk("s2_valid", 32'(m_valid), 1);
    chk("s2_data", 32'(m_data), 16'h0001);
    nc();
    chk("s2_data_hold", 32'(m_data), 16'h0001);
    m_ready = 1'b1;
    wait_cap("s2_count", base + 4, 20);
    chk_seq("s2_seq", base, 16'h0001, 4);
    nc();
    chk("s2_end_busy", 32'(busy), 0);

    // empty stall after the third read
    base = cap.size();
    push_run(16'h0021, 8);
    nc();
    nc();
    nc();
    nc();
    stall_empty = 1'b1;
    #1;
    chk("s3_stall0", 32'(fifo_rd_en), 0);
    nc();
    chk("s3_stall1", 32'(fifo_rd_en), 0);
    stall_empty = 1'b0;
    #1;
    chk("s3_resume", 32'(fifo_rd_en), 1);
    wait_cap("s3_count", base + 8, 60);
    chk_seq("s3_seq", base, 16'h0021, 8);
    nc();
    chk("s3_end_busy", 32'(busy), 0);

    // level threshold
    base = cap.size();
    r0 = rd_total;
    push_run(16'h0031, 3);
    repeat (5) nc();
    chk("s4_lvl3_busy", 32'(busy), 0);
    chk("s4_lvl3_rd", 32'(rd_total - r0), 0);
    push(16'h0034);
    #1;
    chk("s4_lvl4_busy", 32'(busy), 0);
    nc();
    chk("s4_start_busy", 32'(busy), 1);
    chk("s4_start_rden", 32'(fifo_rd_en), 1);
    wait_cap("s4_count", base + 4, 20);
    chk_seq("s4_seq", base, 16'h0031, 4);

    // enable dropped mid-burst
    nc();
    base = cap.size();
    push_run(16'h0041, 8);
    i = 0;
    while (cap.size() < base + 2 && i < 20) begin
      nc();
      i++;
    end
    enable = 1'b0;
    chk("s5_mid_busy", 32'(busy), 1);
    wait_cap("s5_count", base + 4, 20);
    repeat (10) nc();
    chk("s5_no_second", 32'(cap.size()), 32'(base + 4));
    chk("s5_end_busy", 32'(busy), 0);
    chk("s5_level", 32'(fifo_rd_level), 4);
    chk_seq("s5_seq", base, 16'h0041, 4);

    // reset mid-burst with two words buffered
    m_ready = 1'b0;
    enable = 1'b1;
    nc();
    nc();
    nc();
    nc();
    chk("s6_pre_valid", 32'(m_valid), 1);
    rd_rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(m_valid), 0);
    chk("s6_rst_busy", 32'(busy), 0);
    chk("s6_rst_rden", 32'(fifo_rd_en), 0);
    chk("s6_rst_last", 32'(m_last), 0);
    chk("s6_rst_data", 32'(m_data), 0);
    nc();
    enable = 1'b0;
    rd_rst_n = 1'b1;
    nc();
    chk("s6_post_busy", 32'(busy), 0);
    chk("s6_post_valid", 32'(m_valid), 0);
    chk("s6_post_level", 32'(fifo_rd_level), 0);
    base = cap.size();
    m_ready = 1'b1;
    enable = 1'b1;
    push_run(16'h0051, 4);
    wait_cap("s6_count", base + 4, 20);
    chk_seq("s6_seq", base, 16'h0051, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
